fifo_burst_drain: RTL and testbench
===================================

// Module: fifo_burst_drain
// PURPOSE
//  Read-side controller for the request FIFO. Pops entries via the FIFO's first-word-fall-through read port.
//  Batches entries into bursts of up to BURST_MAX beats, started by a fill threshold or an idle timeout.
//  Presents the beats on a registered valid/ready stream toward the DRAM-cache request pipe.
// PARAMETERS
//  DATA_BIT_SIZE  8   width of FIFO entry / out_data
//  FIFO_SIZE      8   depth of attached FIFO; CNT_W = $clog2(FIFO_SIZE)+1
//  BURST_MAX      4   max beats per burst, 1..FIFO_SIZE
//  BATCH_THR      4   fifo_cnt >= BATCH_THR starts a burst immediately, 1..FIFO_SIZE
//  TIMEOUT        16  cycles in WAIT before a partial burst is forced, >=1
// PORTS
//  clk           in   1              clock, rising edge
//  rst_n         in   1              asynchronous active-low reset
//  fifo_empty    in   1              FIFO empty flag
//  fifo_cnt      in   CNT_W          FIFO occupancy, registered in FIFO
//  fifo_rd_data  in   DATA_BIT_SIZE  FIFO head entry, valid when !fifo_empty
//  fifo_rd_en    out  1              pop strobe (combinational)
//  out_valid     out  1              output beat valid
//  out_ready     in   1              downstream accept
//  out_data      out  DATA_BIT_SIZE  output beat
//  out_last      out  1              final beat of burst
//  busy          out  1              state != IDLE
//  stat_bursts   out  16             bursts issued (see CONFIGURATION)
//  stat_tmo      out  16             bursts started by timeout (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async): state=IDLE, timer=0, pops_left=0, out_valid=0, out_data=0, out_last=0, busy=0, stats=0.
//   Reset mid-burst discards the output beat and any unpopped remainder of the burst. Popped entries are lost.
//  States IDLE(0), WAIT(1), DRAIN(2):
//   IDLE:  if fifo_cnt>=BATCH_THR -> DRAIN; else if fifo_cnt!=0 -> WAIT with timer=0.
//   WAIT:  timer++ each cycle. If fifo_cnt>=BATCH_THR or timer==TIMEOUT-1 -> DRAIN.
//          The timeout start counts in stat_tmo only if the threshold was not also met.
//   Entry to DRAIN: pops_left <= min(fifo_cnt, BURST_MAX); stat_bursts++.
//   DRAIN: fifo_rd_en = (pops_left!=0) & !fifo_empty & (!out_valid | out_ready).
//          On pop: out_data<=fifo_rd_data, out_valid<=1, out_last<=(pops_left==1), pops_left--.
//          out_valid&out_ready with no pop clears out_valid.
//          out_valid&out_ready&out_last -> IDLE at the same edge.
//  Latency: pop to out_valid is 1 cycle. Throughput is 1 beat/cycle with out_ready held high.
//   Minimum gap between bursts is 1 IDLE cycle.
//  Backpressure: while out_valid&!out_ready, out_data and out_last hold stable and fifo_rd_en=0.
//  Burst length is fixed at DRAIN entry. Writes into the FIFO during DRAIN never extend the current burst.
//   Only this block pops, so fifo_cnt>=pops_left always holds.
//  fifo_rd_en is never asserted when fifo_empty=1, in IDLE or WAIT, or during reset.
//  Stats saturate at 16'hFFFF.
// CONFIGURATION
//  FIFO_BURST_DRAIN_STAT_EN defined: stat_bursts and stat_tmo counters are implemented as above.
//  FIFO_BURST_DRAIN_STAT_EN undefined: no counter flops; stat_bursts and stat_tmo are tied to 16'h0.
//   All other behaviour is identical.
// TESTING (defaults, STAT_EN defined, out_ready=1 unless stated)
//  1 Write single 8'hA5, then idle -> WAIT for 16 cycles, 1 beat A5 with out_last=1; stat_tmo=1, stat_bursts=1.
//  2 Write 4 entries 01..04 back-to-back -> DRAIN with no WAIT; beats 01..04 on 4 consecutive cycles, last on 04.
//  3 Preload 8 entries 10..17 -> two bursts 10..13 and 14..17, out_last on 13 and 17, 1 IDLE cycle between.
//  4 During test 3, drop out_ready for 3 cycles after beat 11 -> 11 held stable, fifo_rd_en=0, no loss or duplicates.
//  5 Assert rst_n=0 mid-DRAIN -> out_valid=0, busy=0 asynchronously; after release, state=IDLE and stats=0.
//  6 Preload 2 entries, then write 3 more during the timeout-started burst -> burst is 2 beats; remaining 3 follow.

Source files
------------

// File: rtl/fifo_burst_drain_if.sv
// fifo_burst_drain_if: FIFO read port plus valid/ready output stream of the burst drainer.
interface fifo_burst_drain_if #(
    parameter int DATA_BIT_SIZE = 8,
    parameter int FIFO_SIZE     = 8
);
    localparam int CNT_W = $clog2(FIFO_SIZE) + 1;
    logic                     fifo_empty;
    logic [CNT_W-1:0]         fifo_cnt;
    logic [DATA_BIT_SIZE-1:0] fifo_rd_data;
    logic                     fifo_rd_en;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_BIT_SIZE-1:0] out_data;
    logic                     out_last;
    modport master (
        input  fifo_empty, fifo_cnt, fifo_rd_data, out_ready,
        output fifo_rd_en, out_valid, out_data, out_last
    );
    modport slave (
        output fifo_empty, fifo_cnt, fifo_rd_data, out_ready,
        input  fifo_rd_en, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain: batches FWFT FIFO entries into bursts (threshold or idle timeout) on a registered stream.
// Define FIFO_BURST_DRAIN_STAT_EN to build the burst/timeout statistics counters.
module fifo_burst_drain #(
    parameter int DATA_BIT_SIZE = 8,
    parameter int FIFO_SIZE     = 8,
    parameter int BURST_MAX     = 4,
    parameter int BATCH_THR     = 4,
    parameter int TIMEOUT       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_burst_drain_if.master  bus,
    output logic                busy,
    output logic [15:0]         stat_bursts,
    output logic [15:0]         stat_tmo
);
    localparam int CNT_W = $clog2(FIFO_SIZE) + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] THR   = CNT_W'(BATCH_THR);
    localparam logic [CNT_W-1:0] BMAX  = CNT_W'(BURST_MAX);
    localparam logic [TMR_W-1:0] TLAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DRAIN = 2'd2} state_t;

    state_t                   state_q, state_d;
    logic [TMR_W-1:0]         timer_q, timer_d;
    logic [CNT_W-1:0]         pops_left_q, pops_left_d;
    logic                     out_valid_q, out_valid_d;
    logic [DATA_BIT_SIZE-1:0] out_data_q, out_data_d;
    logic                     out_last_q, out_last_d;
    logic                     thr_hit, pop, accept, start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            pops_left_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pops_left_q <= pops_left_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        pops_left_d = pops_left_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        start       = 1'b0;
        thr_hit     = bus.fifo_cnt >= THR;
        accept      = out_valid_q && bus.out_ready;
        pop         = (state_q == DRAIN) && (pops_left_q != '0) && !bus.fifo_empty
                      && (!out_valid_q || bus.out_ready);
        case (state_q)
            IDLE: begin
                if (thr_hit) begin
                    state_d = DRAIN;
                    start   = 1'b1;
                end else if (bus.fifo_cnt != '0) begin
                    state_d = WAIT;
                    timer_d = '0;
                end
            end
            WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                if (thr_hit || timer_q == TLAST) begin
                    state_d = DRAIN;
                    start   = 1'b1;
                end
            end
            DRAIN: state_d = (accept && out_last_q) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
        // Burst length is frozen here; later FIFO writes never extend it.
        if (start) pops_left_d = (bus.fifo_cnt < BMAX) ? bus.fifo_cnt : BMAX;
        if (pop) begin
            out_data_d  = bus.fifo_rd_data;
            out_valid_d = 1'b1;
            out_last_d  = (pops_left_q == CNT_W'(1));
            pops_left_d = pops_left_q - CNT_W'(1);
        end else if (accept) begin
            out_valid_d = 1'b0;
        end
    end

    assign busy           = (state_q != IDLE);
    assign bus.fifo_rd_en = pop;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_last   = out_last_q;

`ifdef FIFO_BURST_DRAIN_STAT_EN
    logic [15:0] bursts_q, bursts_d, tmo_q, tmo_d;
    logic        start_tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bursts_q <= '0;
            tmo_q    <= '0;
        end else begin
            bursts_q <= bursts_d;
            tmo_q    <= tmo_d;
        end
    end

    // A start where threshold and timeout coincide is credited to the threshold.
    always_comb begin
        start_tmo = (state_q == WAIT) && !thr_hit && (timer_q == TLAST);
        bursts_d  = (start && bursts_q != 16'hFFFF) ? bursts_q + 16'd1 : bursts_q;
        tmo_d     = (start_tmo && tmo_q != 16'hFFFF) ? tmo_q + 16'd1 : tmo_q;
    end

    assign stat_bursts = bursts_q;
    assign stat_tmo    = tmo_q;
`else
    assign stat_bursts = 16'h0;
    assign stat_tmo    = 16'h0;
`endif
endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb_fifo_burst_drain: FIFO model plus scoreboard of expected beats for fifo_burst_drain.
module tb_fifo_burst_drain;
    localparam int DW = 8;
    localparam int FS = 8;
    localparam int CW = $clog2(FS) + 1;
`ifdef FIFO_BURST_DRAIN_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        busy;
    logic [15:0] stat_bursts, stat_tmo;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    fifo_burst_drain_if #(.DATA_BIT_SIZE(DW), .FIFO_SIZE(FS)) bus ();

    fifo_burst_drain #(
        .DATA_BIT_SIZE(DW), .FIFO_SIZE(FS), .BURST_MAX(4), .BATCH_THR(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master),
        .busy(busy), .stat_bursts(stat_bursts), .stat_tmo(stat_tmo)
    );

    // FWFT FIFO model: a write of wr_n entries lands in one edge so occupancy can jump.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] wr_v [0:7];
    int            wr_n = 0;
    logic          pop_s = 1'b0;
    logic          empty_r = 1'b1;
    logic [CW-1:0] cnt_r = '0;
    logic [DW-1:0] head_r = '0;

    assign bus.fifo_empty   = empty_r;
    assign bus.fifo_cnt     = cnt_r;
    assign bus.fifo_rd_data = head_r;

    always @(negedge clk) pop_s <= bus.fifo_rd_en;

    always @(posedge clk) begin
        if (!rst_n) fq.delete();
        else begin
            if (pop_s && fq.size() != 0) void'(fq.pop_front());
            for (int i = 0; i < wr_n; i++) fq.push_back(wr_v[i]);
        end
        empty_r <= (fq.size() == 0);
        cnt_r   <= CW'(fq.size());
        head_r  <= (fq.size() != 0) ? fq[0] : '0;
    end

    logic [DW:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic expect_burst(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, base + DW'(i)});
    endtask

    task automatic wr(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) wr_v[i] = base + DW'(i);
        wr_n = n;
        @(posedge clk);
        #1 wr_n = 0;
    endtask

    task automatic lat_to_valid(output int n);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.out_valid) return;
            if (busy) n++;
        end
        n = -1;
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        while ((exp_q.size() != 0 || busy) && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk(tag, 32'(exp_q.size()), 0);
    endtask

    task automatic monitor();
        logic [DW-1:0] hd;
        logic          hl, stall, gap;
        logic [DW:0]   e;
        stall = 1'b0;
        gap   = 1'b0;
        hd    = '0;
        hl    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
                gap   = 1'b0;
            end else begin
                if (bus.fifo_empty) chk("rd_en_when_empty", bus.fifo_rd_en, 0);
                if (stall) begin
                    chk("stall_data", bus.out_data, hd);
                    chk("stall_last", bus.out_last, hl);
                end
                if (bus.out_valid && !bus.out_ready) chk("stall_rd_en", bus.fifo_rd_en, 0);
                if (gap) chk("gap_idle", busy, 0);
                stall = bus.out_valid && !bus.out_ready;
                hd    = bus.out_data;
                hl    = bus.out_last;
                gap   = 1'b0;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) chk("spurious_beat", 32'(exp_q.size()), 1);
                    else begin
                        e = exp_q.pop_front();
                        chk("beat_data", bus.out_data, e[DW-1:0]);
                        chk("beat_last", bus.out_last, e[DW]);
                    end
                    gap = bus.out_last;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_last", bus.out_last, 0);
        chk("rst_rd_en", bus.fifo_rd_en, 0);
        chk("rst_bursts", stat_bursts, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        fork monitor(); join_none

        // single entry drained by timeout
        expect_burst(8'hA5, 1);
        wr(1, 8'hA5);
        lat_to_valid(n);
        chk("t1_latency", n, 17);
        wait_done("t1_drain");
        chk("t1_bursts", stat_bursts, STAT ? 1 : 0);
        chk("t1_tmo", stat_tmo, STAT ? 1 : 0);

        // threshold met at once: no WAIT, back-to-back beats
        expect_burst(8'h01, 4);
        wr(4, 8'h01);
        lat_to_valid(n);
        chk("t2_latency", n, 1);
        repeat (3) begin
            @(negedge clk);
            chk("t2_throughput", bus.out_valid, 1);
        end
        wait_done("t2_drain");
        chk("t2_bursts", stat_bursts, STAT ? 2 : 0);

        // eight entries: two bursts, with backpressure on beat 11
        expect_burst(8'h10, 4);
        expect_burst(8'h14, 4);
        wr(8, 8'h10);
        lat_to_valid(n);
        chk("t3_first", bus.out_data, 8'h10);
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t4_held", bus.out_data, 8'h11);
        chk("t4_rd_en", bus.fifo_rd_en, 0);
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_done("t3_drain");
        chk("t3_bursts", stat_bursts, STAT ? 4 : 0);
        chk("t3_tmo", stat_tmo, STAT ? 1 : 0);

        // asynchronous reset in the middle of a burst
        expect_burst(8'h20, 4);
        wr(4, 8'h20);
        lat_to_valid(n);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", bus.out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_rd_en", bus.fifo_rd_en, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_idle", busy, 0);
        chk("t5_bursts", stat_bursts, 0);
        chk("t5_tmo", stat_tmo, 0);

        // writes during a timeout burst do not extend it
        expect_burst(8'h30, 2);
        expect_burst(8'h32, 3);
        wr(2, 8'h30);
        lat_to_valid(n);
        chk("t6_latency", n, 17);
        wr(3, 8'h32);
        wait_done("t6_drain");
        chk("t6_bursts", stat_bursts, STAT ? 2 : 0);
        chk("t6_tmo", stat_tmo, STAT ? 2 : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_fail);
        $finish;
    end
endmodule
